// File: rtl/vm2002_supplier_tx.sv
// VM2002 supplier-side restock transmitter: FIFO of (item, count, cost) entries sent one per valid pulse.
// Optional checksum output chk enabled by defining VM2002_SUP_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start; FIFO may be loaded
// SEND  | pop FIFO head; drive it on valid next cycle (or drop a zero-count entry)
// GAP   | idle spacing between transmitted entries
module vm2002_supplier_tx #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       hrst,
  input  logic                       srst,
  input  logic                       wr_en,
  input  logic [2:0]                 wr_item,
  input  logic [3:0]                 wr_count,
  input  logic [7:0]                 wr_cost,
  output logic                       wr_full,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       valid,
  output logic [2:0]                 item,
  output logic [3:0]                 count,
  output logic [7:0]                 cost,
  output logic [7:0]                 drop_cnt
`ifdef VM2002_SUP_CHECKSUM_EN
  ,
  output logic [7:0]                 chk
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t         state, state_nxt;
  logic [14:0]    mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [GW-1:0]  gap_cnt;
  logic           done_pend;
  logic           wr_acc, pop, head_drop, last_pop;
  logic           done_now, run_end;
  logic [14:0]    head;

  assign wr_full   = (level == LW'(DEPTH));
  assign wr_acc    = wr_en && !wr_full;
  assign pop       = (state == SEND);
  assign head      = mem[rd_ptr];
  assign head_drop = (head[11:8] == 4'd0);
  // a write landing on the same edge as the last pop keeps the run going
  assign last_pop  = (level == LW'(1)) && !wr_acc;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge hrst) begin
    if (!hrst)
      state <= IDLE;
    else if (srst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_now  = 1'b0;
    run_end   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (level != '0)
            state_nxt = SEND;
          else
            done_now = 1'b1;
        end
      end
      SEND: begin
        if (last_pop) begin
          state_nxt = IDLE;
          run_end   = 1'b1;
        end else if (head_drop || (GAP_CYCLES == 0)) begin
          state_nxt = SEND;
        end else begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(1))
          state_nxt = SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= {wr_item, wr_count, wr_cost};
  end

`ifdef VM2002_SUP_CHECKSUM_EN
  logic [11:0] prod;
  assign prod = 12'(head[7:0]) * 12'(head[11:8]);
`endif

  always_ff @(posedge clk or negedge hrst) begin
    if (!hrst) begin
      level     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      gap_cnt   <= '0;
      done_pend <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      item      <= '0;
      count     <= '0;
      cost      <= '0;
      drop_cnt  <= '0;
`ifdef VM2002_SUP_CHECKSUM_EN
      chk       <= '0;
`endif
    end else if (srst) begin
      level     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      gap_cnt   <= '0;
      done_pend <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      item      <= '0;
      count     <= '0;
      cost      <= '0;
      drop_cnt  <= '0;
`ifdef VM2002_SUP_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      if (wr_acc && !pop)
        level <= level + LW'(1);
      else if (!wr_acc && pop)
        level <= level - LW'(1);
      if (wr_acc)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);

      if (pop)
        gap_cnt <= GW'(GAP_CYCLES);
      else if (state == GAP)
        gap_cnt <= gap_cnt - GW'(1);

      valid <= pop && !head_drop;
      if (pop && !head_drop) begin
        item  <= head[14:12];
        count <= head[11:8];
        cost  <= head[7:0];
      end
      if (pop && head_drop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;

      // done trails the final valid (or drop) by one cycle
      done_pend <= run_end;
      done      <= done_now || done_pend;

`ifdef VM2002_SUP_CHECKSUM_EN
      if ((state == IDLE) && start)
        chk <= '0;
      else if (pop && !head_drop)
        chk <= chk + prod[7:0];
`endif
    end
  end

endmodule

// File: tb/tb_vm2002_supplier_tx.sv
// Bench for vm2002_supplier_tx: directed scenarios plus randomized runs against a queue-based timing model.
module tb_vm2002_supplier_tx;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          hrst = 1'b0;
  logic          srst = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_item = '0;
  logic [3:0]    wr_count = '0;
  logic [7:0]    wr_cost = '0;
  logic          wr_full;
  logic [LW-1:0] level;
  logic          start = 1'b0;
  logic          busy, done, valid;
  logic [2:0]    item;
  logic [3:0]    count;
  logic [7:0]    cost;
  logic [7:0]    drop_cnt;
`ifdef VM2002_SUP_CHECKSUM_EN
  logic [7:0]    chk;
`endif

  vm2002_supplier_tx #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .hrst(hrst), .srst(srst),
    .wr_en(wr_en), .wr_item(wr_item), .wr_count(wr_count), .wr_cost(wr_cost),
    .wr_full(wr_full), .level(level), .start(start),
    .busy(busy), .done(done), .valid(valid),
    .item(item), .count(count), .cost(cost), .drop_cnt(drop_cnt)
`ifdef VM2002_SUP_CHECKSUM_EN
    , .chk(chk)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] it;
    logic [3:0] cn;
    logic [7:0] co;
  } ent_t;

  ent_t mq[$];
  int   m_drop = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic write_entry(input logic [2:0] it, input logic [3:0] cn, input logic [7:0] co);
    ent_t e;
    check("wr_full", wr_full, (mq.size() == DEPTH));
    wr_en = 1'b1; wr_item = it; wr_count = cn; wr_cost = co;
    @(negedge clk);
    wr_en = 1'b0;
    if (mq.size() < DEPTH) begin
      e.it = it; e.cn = cn; e.co = co;
      mq.push_back(e);
    end
    check("level", level, mq.size());
  endtask

  // Model: SEND edges follow start by 1, then each entry costs 1 cycle plus GAP if transmitted.
  task automatic run_and_check();
    bit   expv[64];
    ent_t expe[64];
    ent_t e;
    int   d, d_last, dmax, m_chk;
    bit   empty;
    for (int i = 0; i < 64; i++) expv[i] = 1'b0;
    empty  = (mq.size() == 0);
    d      = 1;
    d_last = 0;
    while (mq.size() > 0) begin
      e = mq.pop_front();
      d_last = d;
      if (e.cn == 0) begin
        if (m_drop < 255) m_drop++;
        d += 1;
      end else begin
        expv[d] = 1'b1;
        expe[d] = e;
        d += 1 + GAP;
      end
    end
    dmax  = empty ? 3 : d_last + 3;
    m_chk = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= dmax; i++) begin
      check("valid", valid, expv[i]);
      if (expv[i]) begin
        check("item", item, expe[i].it);
        check("count", count, expe[i].cn);
        check("cost", cost, expe[i].co);
        m_chk = (m_chk + expe[i].co * expe[i].cn) % 256;
      end
`ifdef VM2002_SUP_CHECKSUM_EN
      check("chk", chk, m_chk);
`endif
      check("done", done, empty ? (i == 0) : (i == d_last + 1));
      check("busy", busy, (!empty && i < d_last));
      @(negedge clk);
    end
    check("level_end", level, 0);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    hrst = 1'b1;
    @(negedge clk);
    check("rst_level", level, 0);
    check("rst_full", wr_full, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_item", item, 0);
    check("rst_count", count, 0);
    check("rst_cost", cost, 0);
    check("rst_drop", drop_cnt, 0);

    // three entries with gap spacing
    write_entry(3'd1, 4'd2, 8'h10);
    write_entry(3'd4, 4'd5, 8'h25);
    write_entry(3'd7, 4'd1, 8'hFF);
    run_and_check();

    // overflow: last two writes dropped
    for (int i = 0; i < DEPTH + 2; i++)
      write_entry(3'(i), 4'(i + 1), 8'(i * 7 + 3));
    check("full_after", wr_full, 1);
    check("level_full", level, DEPTH);
    run_and_check();

    // zero-count entry skipped
    write_entry(3'd2, 4'd0, 8'h30);
    write_entry(3'd3, 4'd4, 8'h05);
    run_and_check();

    // empty start
    run_and_check();

    // checksum pair
    write_entry(3'd1, 4'd2, 8'h10);
    write_entry(3'd4, 4'd3, 8'h60);
    run_and_check();

    // soft reset during GAP
    write_entry(3'd1, 4'd1, 8'h11);
    write_entry(3'd2, 4'd2, 8'h22);
    write_entry(3'd3, 4'd3, 8'h33);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("srst_pre_valid", valid, 1);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    mq.delete();
    m_drop = 0;
    check("srst_valid", valid, 0);
    check("srst_level", level, 0);
    check("srst_busy", busy, 0);
    check("srst_drop", drop_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      check("srst_nodone", done, 0);
      check("srst_novalid", valid, 0);
      @(negedge clk);
    end

    // hard reset mid-SEND
    write_entry(3'd5, 4'd6, 8'h77);
    write_entry(3'd6, 4'd7, 8'h88);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hrst_pre_busy", busy, 1);
    #1 hrst = 1'b0;
    #1;
    check("hrst_valid", valid, 0);
    check("hrst_busy", busy, 0);
    check("hrst_level", level, 0);
    check("hrst_item", item, 0);
    check("hrst_count", count, 0);
    check("hrst_cost", cost, 0);
    check("hrst_done", done, 0);
    @(negedge clk);
    hrst = 1'b1;
    mq.delete();
    m_drop = 0;
    @(negedge clk);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, DEPTH + 2);
      for (int i = 0; i < n; i++)
        write_entry(3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                    8'($urandom_range(0, 255)));
      run_and_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
